// File: rtl/core_pkg.sv
// Shared types for the memory arbiter: FSM state and requester source encodings.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;

    // Bit positions inside the one-hot grant vector from mem_arb_pick.
    localparam int unsigned GntIBit = 0;
    localparam int unsigned GntDBit = 1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational pick between the fetch and load requesters.
// On a tie the requester that was not granted last wins; tying last_grant
// to SRC_I turns this into fixed priority with the load side winning.
module mem_arb_pick
    import core_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  arb_src_t   last_grant,
    output logic [1:0] grant
);

    // One-hot grant; all-zero when nothing is requested.
    always_comb begin
        grant = 2'b00;
        if (i_req && d_req) begin
            if (last_grant == SRC_D) begin
                grant[GntIBit] = 1'b1;
            end else begin
                grant[GntDBit] = 1'b1;
            end
        end else begin
            grant[GntIBit] = i_req;
            grant[GntDBit] = d_req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester read arbiter (instruction fetch / data load) onto one memory port.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate on simultaneous requests;
// otherwise loads win ties and no last-grant register exists.
module mem_arbiter
    import core_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_ack,
    output logic [XLEN-1:0] i_rdata,
    input  logic            d_req,
    input  logic [XLEN-1:0] d_addr,
    output logic            d_ack,
    output logic [XLEN-1:0] d_rdata,
    output logic            m_req,
    output logic [XLEN-1:0] m_addr,
    input  logic            m_ack,
    input  logic [XLEN-1:0] m_rdata,
    output logic            busy
);

    arb_state_t state_q, state_d;
    arb_src_t   last_grant;
    logic [1:0] grant;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_src_t last_grant_q, last_grant_d;
    assign last_grant = last_grant_q;
`else
    assign last_grant = SRC_I;
`endif

    mem_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Next state: arbitrate only from IDLE, release a grant on m_ack.
    always_comb begin
        state_d = state_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant[GntDBit]) begin
                    state_d = GNT_D;
                end else if (grant[GntIBit]) begin
                    state_d = GNT_I;
                end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                if (grant != 2'b00) begin
                    last_grant_d = grant[GntDBit] ? SRC_D : SRC_I;
                end
`endif
            end
            GNT_I, GNT_D: begin
                if (m_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= SRC_I;
`endif
        end else begin
            state_q <= state_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Memory-side request and ack routing decoded straight from the state register.
    always_comb begin
        m_req  = 1'b0;
        m_addr = '0;
        i_ack  = 1'b0;
        d_ack  = 1'b0;
        unique case (state_q)
            GNT_I: begin
                m_req  = 1'b1;
                m_addr = i_addr;
                i_ack  = m_ack;
            end
            GNT_D: begin
                m_req  = 1'b1;
                m_addr = d_addr;
                d_ack  = m_ack;
            end
            default: ;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level ownership model.
module tb_mem_arbiter;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            i_req, d_req, m_ack;
    logic [XLEN-1:0] i_addr, d_addr, m_rdata;
    logic            i_ack, d_ack, m_req, busy;
    logic [XLEN-1:0] i_rdata, d_rdata, m_addr;

    int errors = 0;
    int checks = 0;

    // Model: who owns the memory port (0 none, 1 fetch, 2 load) and who got it last (0 I, 1 D).
    int owner = 0;
    int last  = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    bit rr = 1'b1;
`else
    bit rr = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_ack   (i_ack),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_addr  (d_addr),
        .d_ack   (d_ack),
        .d_rdata (d_rdata),
        .m_req   (m_req),
        .m_addr  (m_addr),
        .m_ack   (m_ack),
        .m_rdata (m_rdata),
        .busy    (busy)
    );

    // Advance one clock edge, applying the arbitration rules to the model.
    task automatic tick();
        @(posedge clk);
        if (!reset_n) begin
            owner = 0;
            last  = 0;
        end else if (owner == 0) begin
            if (i_req && d_req) owner = (rr && last == 1) ? 1 : 2;
            else if (d_req) owner = 2;
            else if (i_req) owner = 1;
            if (rr && owner != 0) last = owner - 1;
        end else if (m_ack) begin
            owner = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; i_req = 1'b0; d_req = 1'b0; m_ack = 1'b1;
        i_addr = '0; d_addr = '0; m_rdata = '0;
        tick(); tick();
        @(negedge clk);
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL reset_m_req got %b want 0", m_req); end
        checks++; if (m_addr !== '0) begin errors++; $display("FAIL reset_m_addr got %h want 0", m_addr); end
        checks++; if (i_ack !== 1'b0) begin errors++; $display("FAIL reset_i_ack got %b want 0", i_ack); end
        checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL reset_d_ack got %b want 0", d_ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        reset_n = 1'b1; m_ack = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        i_req = 1'b1; i_addr = 32'h100;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fetch_arb_busy got %b want 0", busy); end
        tick();
        for (int k = 0; k < 3; k++) begin
            m_ack = (k == 2); m_rdata = (k == 2) ? 32'hDEADBEEF : 32'h0;
            @(negedge clk);
            checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL fetch_m_req got %b want 1", m_req); end
            checks++; if (m_addr !== 32'h100) begin errors++; $display("FAIL fetch_m_addr got %h want 100", m_addr); end
            checks++; if (i_ack !== (k == 2)) begin errors++; $display("FAIL fetch_i_ack k=%0d got %b", k, i_ack); end
            checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL fetch_d_ack got %b want 0", d_ack); end
            if (k == 2) begin
                checks++;
                if (i_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata got %h want deadbeef", i_rdata); end
            end
            tick();
        end
        i_req = 1'b0; m_ack = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fetch_idle_busy got %b want 0", busy); end
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL fetch_idle_m_req got %b want 0", m_req); end
        tick();
    endtask

    task automatic test_d_pulse();
        int n_ack = 0;
        d_req = 1'b1; d_addr = 32'h2000;
        tick();
        d_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_ack = (k == 3); m_rdata = $urandom;
            @(negedge clk);
            checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL pulse_m_req k=%0d got %b want 1", k, m_req); end
            checks++; if (m_addr !== 32'h2000) begin errors++; $display("FAIL pulse_m_addr got %h want 2000", m_addr); end
            if (d_ack === 1'b1) n_ack++;
            tick();
        end
        m_ack = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pulse_release_busy got %b want 0", busy); end
        checks++; if (n_ack != 1) begin errors++; $display("FAIL pulse_d_ack_count got %0d want 1", n_ack); end
        tick();
    endtask

    task automatic test_simultaneous();
        int first;
        int g;
        // Previous grant went to the load side, so round robin favours fetch.
        first = rr ? 1 : 2;
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h300; d_addr = 32'h2000;
        tick();
        for (int n = 0; n < 2; n++) begin
            g = (n == 0) ? first : 3 - first;
            for (int k = 0; k < 2; k++) begin
                m_ack = (k == 1); m_rdata = $urandom;
                @(negedge clk);
                checks++;
                if (m_addr !== ((g == 1) ? 32'h300 : 32'h2000)) begin
                    errors++; $display("FAIL sim_m_addr grant=%0d got %h", g, m_addr);
                end
                checks++;
                if (i_ack !== (g == 1 && k == 1)) begin
                    errors++; $display("FAIL sim_i_ack grant=%0d k=%0d got %b", g, k, i_ack);
                end
                checks++;
                if (d_ack !== (g == 2 && k == 1)) begin
                    errors++; $display("FAIL sim_d_ack grant=%0d k=%0d got %b", g, k, d_ack);
                end
                tick();
            end
            if (g == 1) i_req = 1'b0; else d_req = 1'b0;
            m_ack = 1'b0;
            @(negedge clk);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sim_gap_busy got %b want 0", busy); end
            checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL sim_gap_m_req got %b want 0", m_req); end
            tick();
        end
    endtask

    task automatic test_reset_mid_grant();
        i_req = 1'b1; i_addr = 32'h40;
        tick();
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b want 1", busy); end
        reset_n = 1'b0; i_req = 1'b0;
        tick();
        reset_n = 1'b1; m_ack = 1'b1;
        @(negedge clk);
        checks++; if (i_ack !== 1'b0) begin errors++; $display("FAIL rstmid_i_ack got %b want 0", i_ack); end
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL rstmid_m_req got %b want 0", m_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after got %b want 0", busy); end
        tick();
        m_ack = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_stale_busy got %b want 0", busy); end
        tick();
    endtask

    task automatic test_ack_idle();
        m_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({i_ack, d_ack, busy} !== 3'b000) begin
                errors++; $display("FAIL idle_ack i_ack/d_ack/busy got %b want 000", {i_ack, d_ack, busy});
            end
            tick();
        end
        m_ack = 1'b0;
    endtask

    task automatic test_random();
        bit i_done = 1'b0;
        bit d_done = 1'b0;
        logic [XLEN-1:0] exp_addr;
        for (int c = 0; c < 400; c++) begin
            if (!i_req || i_done) begin i_req = ($urandom_range(2) == 0); i_addr = $urandom; end
            if (!d_req || d_done) begin d_req = ($urandom_range(2) == 0); d_addr = $urandom; end
            m_ack   = ($urandom_range(2) == 0);
            m_rdata = $urandom;
            exp_addr = (owner == 1) ? i_addr : (owner == 2) ? d_addr : '0;
            @(negedge clk);
            checks++; if (m_req !== (owner != 0)) begin errors++; $display("FAIL rnd_m_req c=%0d got %b own=%0d", c, m_req, owner); end
            checks++; if (busy !== (owner != 0)) begin errors++; $display("FAIL rnd_busy c=%0d got %b own=%0d", c, busy, owner); end
            checks++; if (m_addr !== exp_addr) begin errors++; $display("FAIL rnd_m_addr c=%0d got %h want %h", c, m_addr, exp_addr); end
            checks++; if (i_ack !== (owner == 1 && m_ack)) begin errors++; $display("FAIL rnd_i_ack c=%0d got %b own=%0d", c, i_ack, owner); end
            checks++; if (d_ack !== (owner == 2 && m_ack)) begin errors++; $display("FAIL rnd_d_ack c=%0d got %b own=%0d", c, d_ack, owner); end
            if (owner == 1 && m_ack) begin
                checks++; if (i_rdata !== m_rdata) begin errors++; $display("FAIL rnd_i_rdata got %h want %h", i_rdata, m_rdata); end
            end
            if (owner == 2 && m_ack) begin
                checks++; if (d_rdata !== m_rdata) begin errors++; $display("FAIL rnd_d_rdata got %h want %h", d_rdata, m_rdata); end
            end
            i_done = (owner == 1) && m_ack;
            d_done = (owner == 2) && m_ack;
            tick();
        end
        i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_d_pulse();
        test_simultaneous();
        test_reset_mid_grant();
        test_ack_idle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL provide parameter XLEN, default 32, the data and address width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, the reset; reset is synchronous and active-low.
REQ-004 The block SHALL have ports i_req, input, 1, instruction-fetch read request; i_addr, input, XLEN, fetch address.
REQ-005 The block SHALL have ports i_ack, output, 1, fetch completion pulse; i_rdata, output, XLEN, fetch data.
REQ-006 The block SHALL have ports d_req, input, 1, data-load read request; d_addr, input, XLEN, load address.
REQ-007 The block SHALL have ports d_ack, output, 1, load completion pulse; d_rdata, output, XLEN, load data.
REQ-008 The block SHALL have ports m_req, output, 1, memory request; m_addr, output, XLEN, memory address.
REQ-009 The block SHALL have ports m_ack, input, 1, memory completion pulse; m_rdata, input, XLEN, memory data.
REQ-010 The block SHALL have port busy, output, 1, high while a grant is active.

Function
REQ-011 The block SHALL be an FSM with states IDLE, GNT_I and GNT_D.
REQ-012 In IDLE with any request high, the block SHALL move to the chosen grant state at the next edge; with none high, it SHALL stay in IDLE.
REQ-013 The default pick SHALL be fixed priority: d_req beats i_req when both are high in the same cycle.
REQ-014 In GNT_x, m_req SHALL be 1 and m_addr SHALL equal x_addr, combinationally from the state register.
REQ-015 In IDLE, m_req SHALL be 0 and m_addr SHALL be 0.
REQ-016 Requesters SHALL hold req and addr stable until their ack; the block does not latch addr.
REQ-017 In GNT_x, m_ack SHALL pass combinationally to x_ack in the same cycle; the other ack SHALL stay 0.
REQ-018 m_rdata SHALL drive both i_rdata and d_rdata unchanged; data is valid only while the matching ack is high.
REQ-019 On m_ack in GNT_x, the block SHALL return to IDLE at the next edge.
REQ-020 Minimum transaction cost: 1 cycle of arbitration plus memory latency, with at least 1 IDLE cycle between grants.
REQ-021 Once granted, a transaction SHALL run to m_ack even if x_req drops; abort is not supported and x_ack still pulses.
REQ-022 m_ack arriving in IDLE SHALL be ignored: no ack is produced and the state is unchanged.
REQ-023 A new request arriving in the same cycle as m_ack SHALL be arbitrated only from IDLE on the following cycle.
REQ-024 busy SHALL be 1 exactly when the state is not IDLE.

Reset
REQ-025 When reset_n=0 at an edge, the state SHALL become IDLE and the last-grant register SHALL become "instruction".
REQ-026 After reset, outputs SHALL be: m_req=0, m_addr=0, i_ack=0, d_ack=0, busy=0.
REQ-027 Reset mid-grant SHALL abandon the transaction; a stale m_ack after reset SHALL be ignored per REQ-022.

Configuration
REQ-028 Macro MEM_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-029 With the macro defined, simultaneous requests SHALL go to the requester not granted last, and the last-grant register updates on each grant.
REQ-030 Without the macro, fixed priority per REQ-013 SHALL apply, and the last-grant register SHALL NOT be synthesized.
REQ-031 Single requests SHALL be granted identically under both settings.

Structure
REQ-032 The shared package core_pkg SHALL hold the arb_state_t enum (IDLE, GNT_I, GNT_D) and the arb_src_t enum (SRC_I, SRC_D).
REQ-033 The pick logic SHALL be sub-module mem_arb_pick: inputs i_req, d_req and last grant; output a 1-hot grant; purely combinational.

Verification
REQ-034 i_req=1, i_addr=0x100; memory acks 2 cycles after m_req with rdata 0xDEADBEEF -> m_addr=0x100, one-cycle i_ack with i_rdata 0xDEADBEEF, state back to IDLE next cycle.
REQ-035 i_req and d_req rise together, d_addr=0x2000, fixed policy -> GNT_D first; GNT_I follows after one IDLE cycle; i_ack never asserts during GNT_D.
REQ-036 Same stimulus with MEM_ARB_ROUND_ROBIN_EN and last grant = D -> GNT_I first, then GNT_D.
REQ-037 d_req pulsed for 1 cycle, m_ack after 4 cycles -> grant held the full 4 cycles and d_ack pulses once.
REQ-038 reset_n=0 during GNT_I, then m_ack=1 one cycle after release -> IDLE, m_req=0, no i_ack.
REQ-039 m_ack=1 in IDLE with no requests -> no ack output and busy stays 0.
